bip_control_unit: RTL and testbench
===================================

# bip_control_unit

Sequencer for the BIP accumulator datapath. Fetches 16-bit instructions from synchronous program memory, decodes the 5-bit opcode, and drives the datapath controls (SelA, SelB, WrAcc, Op, operand) and the data-memory strobes. Every instruction takes 3 cycles. A free-running cycle counter reports execution length once HLT retires.

## Interface
- PC_WIDTH, 11: program counter and data address width; equals operand width.
- INSTR_WIDTH, 16: instruction word; opcode is [15:11], operand is [10:0].
- COUNT_WIDTH, 16: cycle counter width.

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; sampled in IDLE/HALT to begin execution from address 0
- InstrAddr  out  PC_WIDTH  program memory address (= PC)
- InstrData  in  INSTR_WIDTH  program memory data, valid one cycle after InstrAddr
- DataAddr  out  PC_WIDTH  data memory address
- RdRam  out  1  data memory read strobe
- WrRam  out  1  data memory write strobe (write data = datapath accumulator)
- SelA  out  2  datapath mux A: 0 memory, 1 immediate, 2 adder result
- SelB  out  1  datapath mux B: 0 memory, 1 immediate
- Op  out  1  0 add, 1 subtract
- WrAcc  out  1  accumulator write enable
- operand  out  PC_WIDTH  IR[10:0], to datapath sign-extender
- halted  out  1  high in HALT
- CycleCount  out  COUNT_WIDTH  cycles spent executing since the last start

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE: if start, go to FETCH with PC=0 and CycleCount=0.
- FETCH: InstrAddr=PC, then go to DECODE.
- DECODE: IR<=InstrData. For LD/ADD/SUB, assert RdRam with DataAddr=InstrData[10:0]. If opcode=HLT, go to HALT, else go to EXEC.
- EXEC: drive controls from IR for exactly one cycle, PC<=PC+1, then go to FETCH.
- Opcodes and EXEC controls:
  - 00000 HLT: none; PC does not advance.
  - 00001 STO: WrRam=1, DataAddr=operand.
  - 00010 LD: SelA=0, WrAcc=1.
  - 00011 LDI: SelA=1, WrAcc=1.
  - 00100 ADD: SelA=2, SelB=0, Op=0, WrAcc=1.
  - 00101 ADDI: SelA=2, SelB=1, Op=0, WrAcc=1.
  - 00110 SUB: SelA=2, SelB=0, Op=1, WrAcc=1.
  - 00111 SUBI: SelA=2, SelB=1, Op=1, WrAcc=1.
  - 01000–11111: NOP; no strobes, PC advances.
- Outside EXEC: SelA, SelB, Op, WrAcc and WrRam are 0. RdRam is high only in DECODE as listed above.
- DataAddr holds IR/InstrData operand in DECODE/EXEC, 0 otherwise.
- PC wraps 2047→0 with no flag.
- HALT: halted=1; PC and CycleCount are frozen. start returns to FETCH with PC=0 and CycleCount=0 (restart).
- start is ignored in FETCH, DECODE and EXEC.

## Timing
- Reset values: state IDLE, PC=0, IR=0, CycleCount=0, and every output 0.
- Reset mid-instruction clears all state asynchronously. WrAcc and WrRam fall with rst_n, so no partial write follows.
- CycleCount increments on every clock in FETCH, DECODE and EXEC, and saturates at all-ones.
- Cycles per instruction: 3 (FETCH, DECODE, EXEC).
- HLT reaches HALT 2 cycles after its FETCH, so a program of N non-HLT instructions followed by HLT ends with CycleCount=3N+2.
- Memory-operand data arrives in EXEC, one cycle after the RdRam issued in DECODE. Datapath inputs are therefore valid in the same cycle as WrAcc.
- A STO following a write to the accumulator sees the updated accumulator, because EXEC steps are 3 cycles apart.
- halted asserts in the first HALT cycle.

## Structure
- Package bip_pkg holds:
  - opcode localparams (OP_HLT … OP_SUBI);
  - the state enum;
  - SelA encodings (SELA_MEM, SELA_IMM, SELA_ALU);
  - INSTR_WIDTH and PC_WIDTH defaults.
- Sub-module bip_instruction_decoder: purely combinational, maps opcode to {SelA, SelB, Op, WrAcc, WrRam, RdRam, is_hlt}.
- The FSM, PC, IR and counter stay in bip_control_unit.

## Test plan
- Reset then no start: all outputs stay 0 for 20 cycles, and halted=0.
- Program LDI 5; ADDI 3; STO 10; HLT, with start held 1 cycle:
  - WrAcc pulses in EXEC with SelA=1, then SelA=2/SelB=1/Op=0;
  - WrRam pulses with DataAddr=10;
  - halted=1 and CycleCount=11.
- mem[4]=7; program LD 4; SUB 4; HLT:
  - RdRam is high in both DECODE cycles with DataAddr=4;
  - the SUB EXEC shows SelA=2/SelB=0/Op=1;
  - CycleCount=8.
- Opcode 11111 then HLT: no strobes for the NOP, PC advances to 1, HLT is fetched from address 1.
- rst_n low in the EXEC cycle of STO: WrRam drops immediately and state returns to IDLE with PC=0. After start, execution restarts at 0.
- In HALT, start pulse: PC=0, CycleCount=0, and FETCH follows on the next cycle. A start pulse during EXEC has no effect.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: default widths, opcode encodings,
// datapath mux A encodings, the sequencer state type and the decoded control bundle.
package bip_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT    = 11;
    localparam int unsigned INSTR_WIDTH_DEFAULT = 16;
    localparam int unsigned COUNT_WIDTH_DEFAULT = 16;
    localparam int unsigned OPC_WIDTH           = 5;

    localparam logic [OPC_WIDTH-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPC_WIDTH-1:0] OP_STO  = 5'b00001;
    localparam logic [OPC_WIDTH-1:0] OP_LD   = 5'b00010;
    localparam logic [OPC_WIDTH-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPC_WIDTH-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPC_WIDTH-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPC_WIDTH-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPC_WIDTH-1:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SELA_MEM = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_ALU = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StHalt
    } state_e;

    // Decoded controls for one opcode; rd_ram is consumed in DECODE, the rest in EXEC.
    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
        logic       is_hlt;
    } ctrl_t;

endpackage

// File: rtl/bip_control_unit_if.sv
// Program-memory, data-memory and datapath-control signals of the BIP control unit.
//   master: control unit side (drives addresses, strobes, datapath controls).
//   slave : memory/datapath side (returns InstrData).
interface bip_control_unit_if #(
    parameter int unsigned PC_WIDTH    = bip_pkg::PC_WIDTH_DEFAULT,
    parameter int unsigned INSTR_WIDTH = bip_pkg::INSTR_WIDTH_DEFAULT
);
    logic [PC_WIDTH-1:0]    InstrAddr;
    logic [INSTR_WIDTH-1:0] InstrData;
    logic [PC_WIDTH-1:0]    DataAddr;
    logic                   RdRam;
    logic                   WrRam;
    logic [1:0]             SelA;
    logic                   SelB;
    logic                   Op;
    logic                   WrAcc;
    logic [PC_WIDTH-1:0]    operand;

    modport master (
        output InstrAddr, DataAddr, RdRam, WrRam, SelA, SelB, Op, WrAcc, operand,
        input  InstrData
    );

    modport slave (
        input  InstrAddr, DataAddr, RdRam, WrRam, SelA, SelB, Op, WrAcc, operand,
        output InstrData
    );

endinterface

// File: rtl/bip_instruction_decoder.sv
// Combinational opcode decoder for the BIP control unit.
//   opcode_i : 5-bit opcode
//   ctrl_o   : {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, is_hlt}; unknown opcodes are NOPs
module bip_instruction_decoder
    import bip_pkg::*;
(
    input  logic [OPC_WIDTH-1:0] opcode_i,
    output ctrl_t                ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OP_HLT:  ctrl_o.is_hlt = 1'b1;
            OP_STO:  ctrl_o.wr_ram = 1'b1;
            OP_LD: begin
                ctrl_o.sel_a  = SELA_MEM;
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.rd_ram = 1'b1;
            end
            OP_LDI: begin
                ctrl_o.sel_a  = SELA_IMM;
                ctrl_o.wr_acc = 1'b1;
            end
            OP_ADD: begin
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.rd_ram = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = 1'b1;
                ctrl_o.wr_acc = 1'b1;
            end
            OP_SUB: begin
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.op     = 1'b1;
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.rd_ram = 1'b1;
            end
            OP_SUBI: begin
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = 1'b1;
                ctrl_o.op     = 1'b1;
                ctrl_o.wr_acc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP accumulator sequencer: FETCH/DECODE/EXEC per instruction, HLT parks in HALT.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : level, begins execution at address 0 from IDLE or HALT
//   bus         : program memory, data memory strobes and datapath controls
//   halted      : high while in HALT
//   CycleCount  : saturating count of FETCH/DECODE/EXEC cycles since the last start
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = PC_WIDTH_DEFAULT,
    parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
    parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    bip_control_unit_if.master     bus,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] CycleCount
);

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [OPC_WIDTH-1:0]   opcode;
    logic                   running;
    ctrl_t                  ctrl;

    // In DECODE the instruction is still on the memory bus; afterwards it lives in IR.
    assign opcode  = (state_q == StDecode) ? bus.InstrData[INSTR_WIDTH-1 -: OPC_WIDTH]
                                           : ir_q[INSTR_WIDTH-1 -: OPC_WIDTH];
    assign running = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec);

    bip_instruction_decoder u_decoder (
        .opcode_i (opcode),
        .ctrl_o   (ctrl)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        count_d = count_q;
        unique case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                    count_d = '0;
                end
            end
            StFetch:  state_d = StDecode;
            StDecode: begin
                ir_d    = bus.InstrData;
                state_d = ctrl.is_hlt ? StHalt : StExec;
            end
            StExec: begin
                pc_d    = pc_q + 1'b1;
                state_d = StFetch;
            end
            default:  state_d = StIdle;
        endcase
        if (running && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            count_q <= count_d;
        end
    end

    // Outputs decode from state only, so strobes fall together with rst_n.
    always_comb begin
        bus.InstrAddr = pc_q;
        bus.DataAddr  = '0;
        bus.RdRam     = 1'b0;
        bus.WrRam     = 1'b0;
        bus.SelA      = SELA_MEM;
        bus.SelB      = 1'b0;
        bus.Op        = 1'b0;
        bus.WrAcc     = 1'b0;
        bus.operand   = ir_q[PC_WIDTH-1:0];
        halted        = (state_q == StHalt);
        CycleCount    = count_q;
        case (state_q)
            StDecode: begin
                bus.RdRam    = ctrl.rd_ram;
                bus.DataAddr = bus.InstrData[PC_WIDTH-1:0];
            end
            StExec: begin
                bus.DataAddr = ir_q[PC_WIDTH-1:0];
                bus.SelA     = ctrl.sel_a;
                bus.SelB     = ctrl.sel_b;
                bus.Op       = ctrl.op;
                bus.WrAcc    = ctrl.wr_acc;
                bus.WrRam    = ctrl.wr_ram;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bip_control_unit.sv
// Scoreboard bench for bip_control_unit: directed programs push expected strobe/halt
// events; a negedge monitor pops and compares whenever a strobe or halt entry appears.
module tb_bip_control_unit;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        acc;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        op;
        logic [10:0] addr;
        logic        halted;
        logic [15:0] count;
        logic [10:0] pc;
        logic        chk_op;
        logic [10:0] operand;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halted;
    logic [15:0] CycleCount;

    logic [15:0] prog [0:2047];
    ev_t         exp_q [$];
    logic        halted_prev = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    bip_control_unit_if bus ();

    bip_control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .halted     (halted),
        .CycleCount (CycleCount)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data valid one cycle after the address.
    always @(posedge clk) bus.InstrData <= prog[bus.InstrAddr];

    function automatic ev_t mk(logic rd, logic wr, logic acc, logic [1:0] sa, logic sb,
                               logic op, logic [10:0] addr, logic h, logic [15:0] cnt,
                               logic [10:0] pc, logic chk, logic [10:0] opnd);
        ev_t e;
        e.rd = rd; e.wr = wr; e.acc = acc; e.sel_a = sa; e.sel_b = sb; e.op = op;
        e.addr = addr; e.halted = h; e.count = cnt; e.pc = pc;
        e.chk_op = chk; e.operand = opnd;
        return e;
    endfunction

    function automatic ev_t ex_acc(logic [1:0] sa, logic sb, logic op, logic [10:0] addr,
                                   logic [15:0] cnt, logic [10:0] pc);
        return mk(1'b0, 1'b0, 1'b1, sa, sb, op, addr, 1'b0, cnt, pc, 1'b1, addr);
    endfunction

    function automatic ev_t ex_sto(logic [10:0] addr, logic [15:0] cnt, logic [10:0] pc);
        return mk(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, addr, 1'b0, cnt, pc, 1'b1, addr);
    endfunction

    function automatic ev_t dec_rd(logic [10:0] addr, logic [15:0] cnt, logic [10:0] pc);
        return mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, addr, 1'b0, cnt, pc, 1'b0, 11'd0);
    endfunction

    function automatic ev_t halt_ev(logic [15:0] cnt, logic [10:0] pc);
        return mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 11'd0, 1'b1, cnt, pc, 1'b1, 11'd0);
    endfunction

    function automatic string fmt(ev_t e);
        return $sformatf({"rd=%0b wr=%0b acc=%0b selA=%0d selB=%0b op=%0b addr=%0d ",
                          "halted=%0b count=%0d pc=%0d operand=%0d"},
                         e.rd, e.wr, e.acc, e.sel_a, e.sel_b, e.op, e.addr, e.halted,
                         e.count, e.pc, e.operand);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: any strobe, or the first HALT cycle, is an observable event.
    always @(negedge clk) begin
        ev_t obs;
        ev_t expv;
        if (rst_n && (bus.RdRam || bus.WrRam || bus.WrAcc || (halted && !halted_prev))) begin
            obs.rd = bus.RdRam; obs.wr = bus.WrRam; obs.acc = bus.WrAcc;
            obs.sel_a = bus.SelA; obs.sel_b = bus.SelB; obs.op = bus.Op;
            obs.addr = bus.DataAddr; obs.halted = halted; obs.count = CycleCount;
            obs.pc = bus.InstrAddr; obs.chk_op = 1'b1; obs.operand = bus.operand;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got %s, expected no event", fmt(obs));
            end else begin
                expv = exp_q.pop_front();
                if (!expv.chk_op) begin
                    obs.chk_op  = 1'b0;
                    obs.operand = expv.operand;
                end
                if (obs !== expv) begin
                    n_fail++;
                    $display("FAIL event: got %s, expected %s", fmt(obs), fmt(expv));
                end
            end
        end
        halted_prev = halted;
    end

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_halt(string name);
        int n = 0;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_halted"}, 64'(halted), 64'd1);
        @(negedge clk);
        chk({name, "_all_events_seen"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset, no start: everything stays at 0.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle_outputs_%0d", i),
                64'({bus.InstrAddr, bus.DataAddr, bus.RdRam, bus.WrRam, bus.SelA, bus.SelB,
                     bus.Op, bus.WrAcc, halted, bus.operand, CycleCount}), 64'd0);
        end

        // LDI 5; ADDI 3; STO 10; HLT -- start pulsed again in ADDI EXEC (ignored).
        prog[0] = 16'h1805; prog[1] = 16'h2803; prog[2] = 16'h080A; prog[3] = 16'h0000;
        exp_q.push_back(ex_acc(2'd1, 1'b0, 1'b0, 11'd5, 16'd2, 11'd0));
        exp_q.push_back(ex_acc(2'd2, 1'b1, 1'b0, 11'd3, 16'd5, 11'd1));
        exp_q.push_back(ex_sto(11'd10, 16'd8, 11'd2));
        exp_q.push_back(halt_ev(16'd11, 11'd3));
        pulse_start();
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_halt("progA");
        repeat (4) @(negedge clk);
        chk("halt_frozen_count", 64'(CycleCount), 64'd11);
        chk("halt_frozen_pc", 64'(bus.InstrAddr), 64'd3);

        // LD 4; SUB 4; HLT -- restarted from HALT.
        clear_prog();
        prog[0] = 16'h1004; prog[1] = 16'h3004; prog[2] = 16'h0000;
        exp_q.push_back(dec_rd(11'd4, 16'd1, 11'd0));
        exp_q.push_back(ex_acc(2'd0, 1'b0, 1'b0, 11'd4, 16'd2, 11'd0));
        exp_q.push_back(dec_rd(11'd4, 16'd4, 11'd1));
        exp_q.push_back(ex_acc(2'd2, 1'b0, 1'b1, 11'd4, 16'd5, 11'd1));
        exp_q.push_back(halt_ev(16'd8, 11'd2));
        pulse_start();
        chk("restart_halted", 64'(halted), 64'd0);
        chk("restart_pc", 64'(bus.InstrAddr), 64'd0);
        chk("restart_count", 64'(CycleCount), 64'd0);
        wait_halt("progB");

        // Opcode 11111 (NOP) then HLT: no strobes, HLT fetched from address 1.
        clear_prog();
        prog[0] = 16'hF8FF; prog[1] = 16'h0000;
        exp_q.push_back(halt_ev(16'd5, 11'd1));
        pulse_start();
        wait_halt("progC");

        // LDI 1; STO 7; HLT -- reset asserted in the STO EXEC cycle.
        clear_prog();
        prog[0] = 16'h1801; prog[1] = 16'h0807; prog[2] = 16'h0000;
        exp_q.push_back(ex_acc(2'd1, 1'b0, 1'b0, 11'd1, 16'd2, 11'd0));
        exp_q.push_back(ex_sto(11'd7, 16'd5, 11'd1));
        pulse_start();
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1 chk("sto_exec_wrram", 64'(bus.WrRam), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_wrram", 64'(bus.WrRam), 64'd0);
        chk("reset_wracc", 64'(bus.WrAcc), 64'd0);
        chk("reset_pc", 64'(bus.InstrAddr), 64'd0);
        chk("reset_count", 64'(CycleCount), 64'd0);
        chk("reset_halted", 64'(halted), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_all_events_seen", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        chk("reset_stays_idle_count", 64'(CycleCount), 64'd0);
        exp_q.push_back(ex_acc(2'd1, 1'b0, 1'b0, 11'd1, 16'd2, 11'd0));
        exp_q.push_back(ex_sto(11'd7, 16'd5, 11'd1));
        exp_q.push_back(halt_ev(16'd8, 11'd2));
        pulse_start();
        wait_halt("progD");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
